watch_disp: RTL and testbench

WATCH_DISP -- requirements
Module: watch_disp

---
 rtl/watch_pkg.sv | 28 ++
 rtl/bcd_to_seg.sv | 29 ++
 rtl/watch_disp.sv | 134 +++++++++++++
 tb/tb_watch_disp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the multiplexed watch display.
// Latency: n/a (constants only).
// Backpressure: n/a (no flow control).
package watch_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment encodings, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // A 1 here lights the decimal point after that digit (sec0 and minute0).
    localparam logic [NUM_DIGITS-1:0] DP_DIGIT_MASK = 6'b010100;

    // Digit position of minute1, the only leading-zero-blankable digit.
    localparam int MIN1_DIGIT = 5;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd_i - 4-bit digit code; seg_o - segments {g,f,e,d,c,b,a}, active-low.
module bcd_to_seg
    import watch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/watch_disp.sv
// Six-digit multiplexed 7-segment scanner with ghost blanking, leading-zero blank and blink.
// Latency: outputs registered one clock after the scan state that produced them.
// Backpressure: none; free-running scan, frame_done pulses once per 6*DWELL clocks.
// Ports: clk_1Khz/rst (async active-low); dispbuf (six BCD digits), blank_lz, blink_en;
//        seg/dp/an active-low registered drives; frame_done end-of-scan pulse.
module watch_disp
    import watch_pkg::*;
#(
    parameter int DWELL      = 2,
    parameter int BLINK_HALF = 250
)(
    input  logic        clk_1Khz,
    input  logic        rst,
    input  logic [23:0] dispbuf,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SLOT_W  = $clog2(DWELL);
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DWELL - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [23:0]        snap_q, snap_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_on_q, phase_on_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [5:0]         an_q, an_d;
    logic               fd_q, fd_d;

    logic [3:0]         digit;
    logic [6:0]         digit_seg;

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    // Scan position, snapshot and blink phase.
    always_comb begin
        idx_d  = idx_q;
        slot_d = slot_q + 1'b1;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Loading only at the very start of a frame keeps each frame coherent.
        snap_d = (idx_q == '0 && slot_q == '0) ? dispbuf : snap_q;

        blink_d    = blink_q + 1'b1;
        phase_on_d = phase_on_q;
        if (!blink_en) begin
            blink_d    = '0;
            phase_on_d = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
            blink_d    = '0;
            phase_on_d = ~phase_on_q;
        end
    end

    // Output decode from the current scan state; registered below.
    always_comb begin
        digit = snap_q[3:0];
        an_d  = 6'b111111;
        dp_d  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit   = snap_q[4*k +: 4];
                an_d[k] = 1'b0;
                dp_d    = ~DP_DIGIT_MASK[k];
            end
        end
        seg_d = digit_seg;

        if (blank_lz && idx_q == IDX_W'(MIN1_DIGIT) && snap_q[23:20] == 4'd0) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end

        // Slot cycle 0 turns everything off so the previous digit cannot ghost.
        if (slot_q == '0) begin
            an_d  = 6'b111111;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end

        if (!phase_on_q) begin
            an_d = 6'b111111;
        end

        fd_d = (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            slot_q     <= '0;
            snap_q     <= '0;
            blink_q    <= '0;
            phase_on_q <= 1'b1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= 6'b111111;
            fd_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            snap_q     <= snap_d;
            blink_q    <= blink_d;
            phase_on_q <= phase_on_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_watch_disp.sv
// Bench for watch_disp: a cycle-position reference pushes expected outputs to a
// scoreboard when each clock's inputs are applied; the entry is popped and compared
// just after the edge that produces the corresponding registered outputs.
module tb_watch_disp;

    localparam int DW    = 2;
    localparam int BH    = 250;
    localparam int FRAME = 6 * DW;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] dispbuf;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        frame_done;

    watch_disp #(.DWELL(DW), .BLINK_HALF(BH)) dut (
        .clk_1Khz   (clk),
        .rst        (rst),
        .dispbuf    (dispbuf),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] an;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference state: position in frame before the next edge, consecutive
    // blink-enabled edges so far, and the snapshot currently on display.
    int          m_pos  = 0;
    int          m_bk   = 0;
    logic [23:0] m_snap = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d > 4'd9) return 7'b0111111;
        return tbl[d];
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_bk   = 0;
        m_snap = '0;
        sb.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_an"},  32'(an), 32'h3F);
        check({tag, "_dp"},  32'(dp), 32'h1);
        check({tag, "_fd"},  32'(frame_done), 32'h0);
    endtask

    // One clock with the currently driven inputs.
    task automatic tick();
        exp_t e;
        exp_t g;
        int   idx;
        int   slot;
        logic [3:0] d;
        idx  = m_pos / DW;
        slot = m_pos % DW;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.an  = 6'h3F;
        if (slot != 0) begin
            d = m_snap[idx*4 +: 4];
            e.an[idx] = 1'b0;
            e.seg = seg_of(d);
            e.dp  = !(idx == 2 || idx == 4);
            if (blank_lz && idx == 5 && d == 4'd0) begin
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end
        end
        if (((m_bk / BH) % 2) == 1) e.an = 6'h3F;
        e.fd = (m_pos == FRAME - 1);
        sb.push_back(e);

        if (m_pos == 0) m_snap = dispbuf;
        m_pos = (m_pos + 1) % FRAME;
        m_bk  = blink_en ? m_bk + 1 : 0;

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            check("seg", 32'(seg), 32'(g.seg));
            check("an",  32'(an), 32'(g.an));
            check("dp",  32'(dp), 32'(g.dp));
            check("fd",  32'(frame_done), 32'(g.fd));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int fd_cnt;
        int on_cnt;
        rst      = 1'b0;
        dispbuf  = 24'h123456;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");

        #2;
        rst = 1'b1;
        model_reset();

        // Basic scan; first output after release is the ghost blank of digit 0.
        tick();
        check("first_an_blank", 32'(an), 32'h3F);
        tick();
        check("digit0_is_6", 32'(seg), 32'h02);
        check("digit0_an", 32'(an), 32'h3E);
        fd_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        check("fd_per_3_frames", 32'(fd_cnt), 32'd3);

        // Leading-zero blanking on and off.
        dispbuf  = 24'h059999;
        blank_lz = 1'b1;
        run(2 * FRAME);
        blank_lz = 1'b0;
        run(2 * FRAME);

        // Mid-frame change must wait for the next frame.
        dispbuf = 24'h000000;
        run(FRAME + (FRAME - m_pos) % FRAME);
        run(5);
        dispbuf = 24'h111111;
        run(2 * FRAME);

        // Non-BCD digit and decimal point placement.
        dispbuf = 24'hA00000;
        blank_lz = 1'b1;
        run(2 * FRAME);

        // Random digits changing every clock, including on the load cycle.
        for (int i = 0; i < 6 * FRAME; i++) begin
            dispbuf  = 24'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
            tick();
        end

        // Blink: an alternates 250 on / 250 off while frame_done keeps going.
        dispbuf  = 24'h204512;
        blank_lz = 1'b0;
        blink_en = 1'b1;
        fd_cnt = 0;
        on_cnt = 0;
        for (int i = 0; i < 4 * BH + 12; i++) begin
            tick();
            if (frame_done) fd_cnt++;
            if (i >= BH && i < 2 * BH && an != 6'h3F) on_cnt++;
        end
        check("blink_off_an_idle", 32'(on_cnt), 32'd0);
        check("blink_fd_count", 32'(fd_cnt), 32'((4 * BH + 12) / FRAME));
        // Drop blink partway through an off phase.
        run(BH + 20);
        blink_en = 1'b0;
        run(2 * FRAME);

        // Asynchronous reset during index 3, then restart with a new snapshot.
        dispbuf = 24'h987654;
        while (m_pos / DW != 3) tick();
        tick();
        rst = 1'b0;
        #2;
        check_reset_vals("rst_mid");
        model_reset();
        dispbuf = 24'h314159;
        #1;
        rst = 1'b1;
        run(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
